// File: rtl/uart_loader.sv
// Byte sink behind the command FSM: routes received UART bytes into parameter,
// mask or image-memory destinations and tracks the per-load byte counter.
module uart_loader #(
   parameter int MASK_BYTES = 11,
   parameter int ADDR_W     = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rx_dv,
   input  logic [7:0]              uart_in,
   input  logic [1:0]              uart_sel,
   input  logic [1:0]              para_sel,
   input  logic                    counter_rst,
   output logic [15:0]             counter,
   output logic [7:0]              n_val,
   output logic [7:0]              h_val,
   output logic [7:0]              w_val,
   output logic [7:0]              r_val,
   output logic [MASK_BYTES*8-1:0] mask,
   output logic [15:0]             input_len,
   output logic                    mem_we,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic [7:0]              mem_wdata,
   output logic                    ovf
);

   localparam logic [1:0] SEL_IMAGE = 2'd1;
   localparam logic [1:0] SEL_PARAM = 2'd2;
   localparam logic [1:0] SEL_MASK  = 2'd3;

   logic acc;
   logic at_max;

   assign acc    = rx_dv && (uart_sel != 2'd0);
   assign at_max = (counter == 16'hFFFF);

   // NOTE: all state below uses non-blocking assignments so every route sees
   // the pre-increment counter value sampled at the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         counter <= '0;
         ovf     <= 1'b0;
      end else begin
         if (counter_rst)
            counter <= '0;
         else if (acc && !at_max)
            counter <= counter + 16'd1;
         if (acc && at_max)
            ovf <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_val <= '0;
         h_val <= '0;
         w_val <= '0;
         r_val <= '0;
      end else if (acc && uart_sel == SEL_PARAM) begin
         case (para_sel)
            2'd0:    n_val <= uart_in;
            2'd1:    h_val <= uart_in;
            2'd2:    w_val <= uart_in;
            default: r_val <= uart_in;
         endcase
      end
   end

   // Bytes beyond MASK_BYTES match no slot and are dropped after counting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mask <= '0;
      end else if (acc && uart_sel == SEL_MASK) begin
         for (int k = 0; k < MASK_BYTES; k++) begin
            if (counter == 16'(k))
               mask[8*k +: 8] <= uart_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         input_len <= '0;
      else
         input_len <= 16'(h_val) * 16'(w_val);
   end

   // The write is captured independently of counter_rst so the final byte of a
   // load still lands after the FSM has dropped back to IDLE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= acc && (uart_sel == SEL_IMAGE);
         if (acc && uart_sel == SEL_IMAGE) begin
            mem_addr  <= counter[ADDR_W-1:0];
            mem_wdata <= uart_in;
         end
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Directed self-checking bench for uart_loader: one task per scenario with
// hand-computed expectations.
module tb_uart_loader;

   localparam int MASK_BYTES = 11;
   localparam int ADDR_W     = 16;

   logic                    clk;
   logic                    rst;
   logic                    rx_dv;
   logic [7:0]              uart_in;
   logic [1:0]              uart_sel;
   logic [1:0]              para_sel;
   logic                    counter_rst;
   logic [15:0]             counter;
   logic [7:0]              n_val, h_val, w_val, r_val;
   logic [MASK_BYTES*8-1:0] mask;
   logic [15:0]             input_len;
   logic                    mem_we;
   logic [ADDR_W-1:0]       mem_addr;
   logic [7:0]              mem_wdata;
   logic                    ovf;

   int compared   = 0;
   int mismatched = 0;

   logic [MASK_BYTES*8-1:0] exp_mask;

   uart_loader #(.MASK_BYTES(MASK_BYTES), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .rx_dv(rx_dv), .uart_in(uart_in),
      .uart_sel(uart_sel), .para_sel(para_sel), .counter_rst(counter_rst),
      .counter(counter), .n_val(n_val), .h_val(h_val), .w_val(w_val),
      .r_val(r_val), .mask(mask), .input_len(input_len), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .ovf(ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rx_dv       = 1'b0;
      uart_in     = 8'h00;
      uart_sel    = 2'd0;
      para_sel    = 2'd0;
      counter_rst = 1'b0;
   endtask

   task automatic clear_counter();
      idle_inputs();
      counter_rst = 1'b1;
      step();
      counter_rst = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b0;
      #1;
      compared++;
      if ({counter, n_val, h_val, w_val, r_val, input_len, mem_we, mem_addr, mem_wdata, ovf} !== '0
          || mask !== '0) begin
         mismatched++;
         $display("FAIL reset_state: counter=%h n=%h h=%h w=%h r=%h len=%h we=%b addr=%h data=%h ovf=%b mask=%h, all required 0",
                  counter, n_val, h_val, w_val, r_val, input_len, mem_we, mem_addr, mem_wdata, ovf, mask);
      end
      step();
      rst = 1'b1;
      step();
   endtask

   task automatic test_params();
      uart_sel = 2'd2; rx_dv = 1'b1;
      para_sel = 2'd1; uart_in = 8'h0A;
      step();
      compared++;
      if (h_val !== 8'h0A || counter !== 16'd1) begin
         mismatched++;
         $display("FAIL param_h: h=%h counter=%0d, required h=0a counter=1", h_val, counter);
      end
      para_sel = 2'd2; uart_in = 8'h0C;
      step();
      compared++;
      if (w_val !== 8'h0C || counter !== 16'd2 || input_len !== 16'd0) begin
         mismatched++;
         $display("FAIL param_w: w=%h counter=%0d len=%0d, required w=0c counter=2 len=0", w_val, counter, input_len);
      end
      rx_dv = 1'b0;
      step();
      compared++;
      if (input_len !== 16'd120 || n_val !== 8'h00 || r_val !== 8'h00) begin
         mismatched++;
         $display("FAIL input_len: len=%0d n=%h r=%h, required len=120 n=00 r=00", input_len, n_val, r_val);
      end
      rx_dv = 1'b1; para_sel = 2'd0; uart_in = 8'h03;
      step();
      para_sel = 2'd3; uart_in = 8'h02;
      step();
      rx_dv = 1'b0;
      compared++;
      if (n_val !== 8'h03 || r_val !== 8'h02 || h_val !== 8'h0A || w_val !== 8'h0C || counter !== 16'd4) begin
         mismatched++;
         $display("FAIL param_nr: n=%h r=%h h=%h w=%h counter=%0d, required n=03 r=02 h=0a w=0c counter=4",
                  n_val, r_val, h_val, w_val, counter);
      end
      clear_counter();
      compared++;
      if (counter !== 16'd0) begin
         mismatched++;
         $display("FAIL counter_clear: counter=%0d, required 0", counter);
      end
   endtask

   task automatic test_mask();
      uart_sel = 2'd3; rx_dv = 1'b1;
      for (int i = 0; i < 12; i++) begin
         uart_in = (i < 11) ? 8'(i + 1) : 8'hFF;
         step();
      end
      rx_dv = 1'b0;
      for (int k = 0; k < MASK_BYTES; k++) exp_mask[8*k +: 8] = 8'(k + 1);
      compared++;
      if (mask !== exp_mask || counter !== 16'd12) begin
         mismatched++;
         $display("FAIL mask_load: mask=%h counter=%0d, required mask=%h counter=12", mask, counter, exp_mask);
      end
      clear_counter();
      uart_sel = 2'd3; rx_dv = 1'b1;
      uart_in = 8'h77; step();
      uart_in = 8'h88; step();
      rx_dv = 1'b0;
      exp_mask[7:0]  = 8'h77;
      exp_mask[15:8] = 8'h88;
      compared++;
      if (mask !== exp_mask || counter !== 16'd2) begin
         mismatched++;
         $display("FAIL mask_partial: mask=%h counter=%0d, required mask=%h counter=2", mask, counter, exp_mask);
      end
      clear_counter();
   endtask

   task automatic test_back_to_back();
      compared++;
      if (mem_we !== 1'b0) begin
         mismatched++;
         $display("FAIL we_idle: we=%b, required 0", mem_we);
      end
      uart_sel = 2'd1; rx_dv = 1'b1; uart_in = 8'h55;
      step();
      compared++;
      if (mem_we !== 1'b1 || mem_addr !== 16'd0 || mem_wdata !== 8'h55) begin
         mismatched++;
         $display("FAIL image_w0: we=%b addr=%h data=%h, required we=1 addr=0000 data=55", mem_we, mem_addr, mem_wdata);
      end
      uart_in = 8'hAA;
      step();
      compared++;
      if (mem_we !== 1'b1 || mem_addr !== 16'd1 || mem_wdata !== 8'hAA) begin
         mismatched++;
         $display("FAIL image_w1: we=%b addr=%h data=%h, required we=1 addr=0001 data=aa", mem_we, mem_addr, mem_wdata);
      end
      rx_dv = 1'b0;
      step();
      compared++;
      if (mem_we !== 1'b0 || counter !== 16'd2) begin
         mismatched++;
         $display("FAIL image_end: we=%b counter=%0d, required we=0 counter=2", mem_we, counter);
      end
      clear_counter();
   endtask

   task automatic test_discard();
      uart_sel = 2'd0; para_sel = 2'd1; rx_dv = 1'b1; uart_in = 8'h6E;
      step();
      rx_dv = 1'b0;
      compared++;
      if (counter !== 16'd0 || mem_we !== 1'b0 || h_val !== 8'h0A || n_val !== 8'h03
          || w_val !== 8'h0C || r_val !== 8'h02 || mask !== exp_mask) begin
         mismatched++;
         $display("FAIL discard: counter=%0d we=%b n=%h h=%h w=%h r=%h mask=%h, required counter=0 we=0 n=03 h=0a w=0c r=02 mask=%h",
                  counter, mem_we, n_val, h_val, w_val, r_val, mask, exp_mask);
      end
   endtask

   task automatic test_clear_collision();
      uart_sel = 2'd1; rx_dv = 1'b1;
      uart_in = 8'h10; step();
      uart_in = 8'h11; step();
      counter_rst = 1'b1; uart_in = 8'h99;
      step();
      compared++;
      if (counter !== 16'd0 || mem_we !== 1'b1 || mem_addr !== 16'd2 || mem_wdata !== 8'h99) begin
         mismatched++;
         $display("FAIL clear_image: counter=%0d we=%b addr=%h data=%h, required counter=0 we=1 addr=0002 data=99",
                  counter, mem_we, mem_addr, mem_wdata);
      end
      uart_sel = 2'd2; para_sel = 2'd3; uart_in = 8'h21;
      step();
      rx_dv = 1'b0; counter_rst = 1'b0;
      compared++;
      if (counter !== 16'd0 || r_val !== 8'h21 || mem_we !== 1'b0) begin
         mismatched++;
         $display("FAIL clear_param: counter=%0d r=%h we=%b, required counter=0 r=21 we=0", counter, r_val, mem_we);
      end
   endtask

   task automatic test_overflow();
      clear_counter();
      uart_sel = 2'd1; rx_dv = 1'b1; uart_in = 8'h5A;
      for (int i = 0; i < 65535; i++) step();
      compared++;
      if (counter !== 16'hFFFF || ovf !== 1'b0 || mem_addr !== 16'hFFFE) begin
         mismatched++;
         $display("FAIL fill_max: counter=%h ovf=%b addr=%h, required counter=ffff ovf=0 addr=fffe", counter, ovf, mem_addr);
      end
      uart_in = 8'hC3;
      step();
      rx_dv = 1'b0;
      compared++;
      if (counter !== 16'hFFFF || ovf !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'hFFFF || mem_wdata !== 8'hC3) begin
         mismatched++;
         $display("FAIL overflow: counter=%h ovf=%b we=%b addr=%h data=%h, required counter=ffff ovf=1 we=1 addr=ffff data=c3",
                  counter, ovf, mem_we, mem_addr, mem_wdata);
      end
      clear_counter();
      compared++;
      if (counter !== 16'd0 || ovf !== 1'b1) begin
         mismatched++;
         $display("FAIL ovf_sticky: counter=%0d ovf=%b, required counter=0 ovf=1", counter, ovf);
      end
   endtask

   task automatic test_reset_mid_load();
      uart_sel = 2'd1; rx_dv = 1'b1; uart_in = 8'hE7;
      step();
      rx_dv = 1'b0;
      compared++;
      if (mem_we !== 1'b1) begin
         mismatched++;
         $display("FAIL pre_reset_we: we=%b, required 1", mem_we);
      end
      rst = 1'b0;
      #1;
      compared++;
      if ({counter, n_val, h_val, w_val, r_val, input_len, mem_we, mem_addr, mem_wdata, ovf} !== '0
          || mask !== '0) begin
         mismatched++;
         $display("FAIL async_reset: counter=%h n=%h h=%h w=%h r=%h len=%h we=%b addr=%h data=%h ovf=%b mask=%h, all required 0",
                  counter, n_val, h_val, w_val, r_val, input_len, mem_we, mem_addr, mem_wdata, ovf, mask);
      end
      idle_inputs();
      step();
      rst = 1'b1;
      step();
   endtask

   initial begin
      exp_mask = '0;
      test_reset();
      test_params();
      test_mask();
      test_back_to_back();
      test_discard();
      test_clear_collision();
      test_overflow();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
